// File: rtl/logic_sweep_pkg.sv
// ============================================================================
// Module   : logic_sweep_pkg
// Purpose  : Shared types and constants for the logic_sweep_checker engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

package logic_sweep_pkg;

    localparam int NUM_VEC = 8;
    localparam int IDX_W   = 3;
    localparam int CNT_W   = 4;

    // a & (b | c), indexed by {a,b,c}
    localparam logic [NUM_VEC-1:0] TRUTH_AND_OR = 8'b1110_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : logic_sweep_pkg

`default_nettype wire

// File: rtl/logic_sweep_checker.sv
// ============================================================================
// Module   : logic_sweep_checker
// Purpose  : Sweeps all 8 input vectors of a 3-in/1-out block, compares the
//            sampled result to TRUTH and reports pass / mismatch count.
//            Optional LOGIC_SWEEP_ERR_LOG_EN adds first_err_idx / err_valid.
// Revision : 1.0
// ============================================================================
`default_nettype none

module logic_sweep_checker
    import logic_sweep_pkg::*;
#(
    parameter int                 SETTLE_CYCLES = 1,
    parameter logic [NUM_VEC-1:0] TRUTH         = TRUTH_AND_OR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dut_q,
    output logic             drv_a,
    output logic             drv_b,
    output logic             drv_c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt
`ifdef LOGIC_SWEEP_ERR_LOG_EN
    ,
    output logic [IDX_W-1:0] first_err_idx,
    output logic             err_valid
`endif
);

    localparam logic [CNT_W-1:0] C_SETTLE   = CNT_W'(SETTLE_CYCLES);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_VEC - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [CNT_W-1:0]   err_q,   err_d;
    logic               pass_q,  pass_d;
    logic               mismatch;
    logic [CNT_W-1:0]   err_inc;
`ifdef LOGIC_SWEEP_ERR_LOG_EN
    logic [IDX_W-1:0]   ferr_idx_q, ferr_idx_d;
    logic               ferr_vld_q, ferr_vld_d;
`endif

    assign mismatch = (dut_q != TRUTH[idx_q]);
    assign err_inc  = err_q + {{(CNT_W-1){1'b0}}, mismatch};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        pass_d  = pass_q;
`ifdef LOGIC_SWEEP_ERR_LOG_EN
        ferr_idx_d = ferr_idx_q;
        ferr_vld_d = ferr_vld_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    cnt_d   = C_SETTLE;
                    err_d   = '0;
                    pass_d  = 1'b0;
`ifdef LOGIC_SWEEP_ERR_LOG_EN
                    ferr_idx_d = '0;
                    ferr_vld_d = 1'b0;
`endif
                end
            end
            RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Last edge of the hold: sample and advance.
                    err_d = err_inc;
`ifdef LOGIC_SWEEP_ERR_LOG_EN
                    if (mismatch && !ferr_vld_q) begin
                        ferr_idx_d = idx_q;
                        ferr_vld_d = 1'b1;
                    end
`endif
                    if (idx_q == C_LAST_IDX) begin
                        state_d = DONE;
                        pass_d  = (err_inc == '0);
                    end else begin
                        idx_d = idx_q + 1'b1;
                        cnt_d = C_SETTLE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

`ifdef LOGIC_SWEEP_ERR_LOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ferr_idx_q <= '0;
            ferr_vld_q <= 1'b0;
        end else begin
            ferr_idx_q <= ferr_idx_d;
            ferr_vld_q <= ferr_vld_d;
        end
    end

    assign first_err_idx = ferr_idx_q;
    assign err_valid     = ferr_vld_q;
`endif

    // Drive lines are the registered vector index itself.
    assign drv_a   = idx_q[2];
    assign drv_b   = idx_q[1];
    assign drv_c   = idx_q[0];
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign pass    = pass_q;
    assign err_cnt = err_q;

endmodule : logic_sweep_checker

`default_nettype wire

// File: doc/logic_sweep_checker.md
# logic_sweep_checker

Sequential stimulus/response engine for small combinational logic blocks under test. On a start request it drives every one of the 8 input combinations onto three drive lines and waits a programmable settle time. It samples the block's single-bit result and compares it against a parameterised truth table, then reports pass/fail and an error count. It sits beside any 3-input/1-output logic block in self-test benches and on-chip BIST wrappers.

## Interface
Parameters:
- SETTLE_CYCLES, 1: extra cycles held per vector before sampling; range 0–15.
- TRUTH, 8'b1110_0000: expected result per vector; bit i is the expected value for index i = {a,b,c}. The default encodes a & (b | c).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  sweep request; sampled only in IDLE.
- dut_q  in  1  result from the block under test.
- drv_a, drv_b, drv_c  out  1 each  registered stimulus, equal to {idx[2],idx[1],idx[0]}.
- busy  out  1  high while a sweep is in progress.
- done  out  1  single-cycle pulse at sweep end.
- pass  out  1  high when the last completed sweep had zero mismatches.
- err_cnt  out  4  mismatch count of the current or last sweep, 0–8.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE: if start=1 at the edge, go to RUN. On the same edge: idx=0, drv=000, cnt=SETTLE_CYCLES, err_cnt=0, busy=1.
- RUN, cnt≠0: cnt decrements by 1 per cycle.
- RUN, cnt=0: compare dut_q to TRUTH[idx]; a mismatch increments err_cnt.
  - idx<7: idx++, drv updated, cnt reloaded.
  - idx=7: go to DONE.
- DONE: lasts one cycle with done=1 and busy=0. pass=(err_cnt==0) is registered on entry. The FSM then returns to IDLE.
- pass and err_cnt hold their values until the next accepted start. At that start, err_cnt clears and pass clears to 0.
- start while in RUN or DONE is ignored. No queuing.
- err_cnt is 4 bits and cannot overflow (maximum 8).

## Timing
- Reset values: busy=0, done=0, pass=0, err_cnt=0, drv_*=0, state=IDLE.
- Reset asserted mid-sweep aborts immediately to reset values. No done pulse is produced.
- Each vector is held for SETTLE_CYCLES+1 cycles. dut_q is sampled at the last edge of the hold.
- busy is high for exactly 8·(SETTLE_CYCLES+1) cycles, starting the cycle after start is accepted.
- done is high in the cycle immediately after busy falls. pass and err_cnt are final in that same cycle.
- Earliest next start is accepted at the edge that ends DONE + 1, i.e. in IDLE.

## Configuration
- LOGIC_SWEEP_ERR_LOG_EN defined: adds outputs first_err_idx[2:0] and err_valid.
  - first_err_idx captures idx at the first mismatch of a sweep.
  - err_valid goes high with it.
  - Both clear on accepted start and on reset.
- LOGIC_SWEEP_ERR_LOG_EN undefined: neither port exists and no capture logic is built.

## Structure
- Shared package logic_sweep_pkg contains:
  - state enum {IDLE, RUN, DONE}
  - NUM_VEC=8, IDX_W=3, CNT_W=4
  - default truth constant TRUTH_AND_OR=8'b1110_0000
- Single module; no sub-module is needed. The settle counter is inline.

## Test plan
- Block under test computes a&(b|c), SETTLE_CYCLES=1, one-cycle start pulse → drv steps 000…111, each held 2 cycles. busy high for 16 cycles, then a done pulse with pass=1 and err_cnt=0.
- Block under test tied to 0, default TRUTH → err_cnt=3, pass=0. With LOGIC_SWEEP_ERR_LOG_EN: first_err_idx=5, err_valid=1.
- Block under test computes b&(a|c), default TRUTH → mismatches at idx 3 and 5: err_cnt=2, pass=0, first_err_idx=3.
- SETTLE_CYCLES=0, correct block under test → busy for exactly 8 cycles, done on cycle 9, pass=1.
- start held high throughout → sweeps run back-to-back, separated by the DONE cycle and one IDLE cycle. Each sweep's result is identical; err_cnt is cleared between sweeps.
- rst_n pulsed low while idx=4 → all outputs 0 asynchronously, no done pulse. A later start gives a full 8-vector sweep from idx 0.
